// File: rtl/prochot_monitor.sv
// PROCHOT# monitor: synchronizes and debounces the pin, classifies CPU vs board
// origin, counts CPU events, raises a BMC interrupt and measures assertion time.
module prochot_monitor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 2000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        PWRGD_SYS_PWROK,
    input  logic        FM_SKTOCC_LVT3_N,
    input  logic        FM_PROCHOT_LVC3_N_IN,
    input  logic        iProchotDrive_n,
    input  logic        iAck,
    output logic        oProchotDeb,
    output logic        oCpuOrigin,
    output logic        oIrq_n,
    output logic [7:0]  oEventCnt,
    output logic [15:0] oLastDurMs
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_ASSERT,
        ASSERTED,
        DEB_DEASSERT
    } state_t;

    state_t        state_q, state_d;
    logic          pin_meta_q, pin_sync_q;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   dur_q, dur_d;
    logic [15:0]   last_dur_q, last_dur_d;
    logic [7:0]    evt_cnt_q, evt_cnt_d;
    logic          irq_n_q, irq_n_d;
    logic          origin_q, origin_d;

    logic          mask;
    logic          pin_low;
    logic          tick;
    logic          active;
    logic [15:0]   dur_inc;
    logic [7:0]    evt_inc;

    assign mask    = !PWRGD_SYS_PWROK || FM_SKTOCC_LVT3_N;
    assign pin_low = !pin_sync_q;
    assign tick    = (presc_q == TICK_LAST);
    assign active  = (state_q == ASSERTED) || (state_q == DEB_DEASSERT);
    assign dur_inc = (dur_q == 16'hFFFF) ? dur_q : dur_q + 16'd1;
    assign evt_inc = (evt_cnt_q == 8'hFF) ? evt_cnt_q : evt_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        presc_d    = presc_q;
        dur_d      = dur_q;
        last_dur_d = last_dur_q;
        evt_cnt_d  = evt_cnt_q;
        irq_n_d    = irq_n_q;
        origin_d   = origin_q;

        if (iAck) begin
            irq_n_d = 1'b1;
        end

        if (mask) begin
            // Partial assertion is dropped; reported values are frozen.
            state_d   = IDLE;
            deb_cnt_d = '0;
            presc_d   = '0;
            dur_d     = '0;
        end else begin
            if (active) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    dur_d = dur_inc;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (pin_low) begin
                        state_d   = DEB_ASSERT;
                        deb_cnt_d = CW'(1);
                    end
                end
                DEB_ASSERT: begin
                    if (!pin_low) begin
                        state_d   = IDLE;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q >= DEB_LAST) begin
                        state_d   = ASSERTED;
                        deb_cnt_d = '0;
                        presc_d   = '0;
                        dur_d     = '0;
                        origin_d  = iProchotDrive_n;
                        // A new CPU event outranks a same-cycle acknowledge.
                        if (iProchotDrive_n) begin
                            evt_cnt_d = evt_inc;
                            irq_n_d   = 1'b0;
                        end
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
                ASSERTED: begin
                    if (!pin_low) begin
                        state_d   = DEB_DEASSERT;
                        deb_cnt_d = CW'(1);
                    end
                end
                DEB_DEASSERT: begin
                    if (pin_low) begin
                        state_d   = ASSERTED;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q >= DEB_LAST) begin
                        state_d    = IDLE;
                        deb_cnt_d  = '0;
                        last_dur_d = tick ? dur_inc : dur_q;
                        presc_d    = '0;
                        dur_d      = '0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pin_meta_q <= 1'b1;
            pin_sync_q <= 1'b1;
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            presc_q    <= '0;
            dur_q      <= '0;
            last_dur_q <= '0;
            evt_cnt_q  <= '0;
            irq_n_q    <= 1'b1;
            origin_q   <= 1'b0;
        end else begin
            pin_meta_q <= FM_PROCHOT_LVC3_N_IN;
            pin_sync_q <= pin_meta_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            presc_q    <= presc_d;
            dur_q      <= dur_d;
            last_dur_q <= last_dur_d;
            evt_cnt_q  <= evt_cnt_d;
            irq_n_q    <= irq_n_d;
            origin_q   <= origin_d;
        end
    end

    assign oProchotDeb = active;
    assign oCpuOrigin  = origin_q;
    assign oIrq_n      = irq_n_q;
    assign oEventCnt   = evt_cnt_q;
    assign oLastDurMs  = last_dur_q;

endmodule

// File: doc/prochot_monitor.md
PROCHOT_MONITOR -- requirements
Module: prochot_monitor

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized samples needed to accept a PROCHOT# level change.
REQ-002 The block SHALL have parameter TICK_DIV, default 2000, meaning iClk cycles per 1 ms duration tick (2 MHz clock).
REQ-003 The block SHALL have port iClk, input, 1 bit: 2 MHz clock, the only clock.
REQ-004 The block SHALL have port iRst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port PWRGD_SYS_PWROK, input, 1 bit: system power good; monitoring is enabled only while it is high.
REQ-006 The block SHALL have port FM_SKTOCC_LVT3_N, input, 1 bit: socket occupied, active low; when high the socket is empty and monitoring is disabled.
REQ-007 The block SHALL have port FM_PROCHOT_LVC3_N_IN, input, 1 bit: sensed PROCHOT# pin level, asynchronous.
REQ-008 The block SHALL have port iProchotDrive_n, input, 1 bit: the board's own PROCHOT# drive (low = board forcing throttle).
REQ-009 The block SHALL have port iAck, input, 1 bit: single-cycle BMC acknowledge that clears the pending interrupt.
REQ-010 The block SHALL have port oProchotDeb, output, 1 bit: debounced PROCHOT# active, active high.
REQ-011 The block SHALL have port oCpuOrigin, output, 1 bit: the current or last assertion was CPU-originated.
REQ-012 The block SHALL have port oIrq_n, output, 1 bit: event pending to the BMC, active low.
REQ-013 The block SHALL have port oEventCnt, output, 8 bits: count of CPU-originated assertions, saturating.
REQ-014 The block SHALL have port oLastDurMs, output, 16 bits: duration in ms of the last completed assertion, saturating.

Function
REQ-015 FM_PROCHOT_LVC3_N_IN SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-016 The FSM SHALL have exactly four states: IDLE, DEB_ASSERT, ASSERTED, DEB_DEASSERT.
REQ-017 IDLE SHALL go to DEB_ASSERT when the synchronized pin is low.
REQ-018 DEB_ASSERT SHALL go to ASSERTED after DEBOUNCE_CYCLES consecutive low samples, and SHALL return to IDLE on any high sample.
REQ-019 ASSERTED SHALL go to DEB_DEASSERT when the synchronized pin is high.
REQ-020 DEB_DEASSERT SHALL go to IDLE after DEBOUNCE_CYCLES consecutive high samples, and SHALL return to ASSERTED on any low sample without counting a new event.
REQ-021 oProchotDeb SHALL be high exactly in ASSERTED and DEB_DEASSERT; it rises DEBOUNCE_CYCLES+2 iClk edges after the pin's first low sample.
REQ-022 On the transition into ASSERTED, the origin SHALL be latched: oCpuOrigin = 1 if iProchotDrive_n is high in that cycle, 0 otherwise.
REQ-023 oEventCnt and oIrq_n SHALL change only on entry to ASSERTED with a CPU origin.
REQ-024 On a CPU-origin entry, oEventCnt SHALL increment and hold at 255.
REQ-025 On a CPU-origin entry, oIrq_n SHALL be driven low.
REQ-026 A board-origin entry SHALL leave oEventCnt and oIrq_n unchanged.
REQ-027 iAck high SHALL set oIrq_n high in the next cycle.
REQ-028 If iAck and a CPU-origin entry occur in the same cycle, the entry SHALL win and oIrq_n SHALL be 0.
REQ-029 iAck SHALL NOT affect oEventCnt.
REQ-030 On entry to ASSERTED, the ms prescaler and the duration accumulator SHALL both be cleared.
REQ-031 The prescaler SHALL run in ASSERTED and DEB_DEASSERT; each TICK_DIV cycles it SHALL increment the accumulator, which holds at 65535.
REQ-032 On the DEB_DEASSERT->IDLE transition, the accumulator SHALL be copied to oLastDurMs.
REQ-033 While PWRGD_SYS_PWROK is low or FM_SKTOCC_LVT3_N is high, the FSM SHALL be forced to IDLE.
REQ-034 During that masking, oProchotDeb SHALL be forced to 0 and no event or duration update SHALL occur.
REQ-035 During that masking, oEventCnt, oLastDurMs, oIrq_n and oCpuOrigin SHALL hold their values.
REQ-036 If masking interrupts an assertion, the partial duration SHALL be discarded.

Reset
REQ-037 While iRst is high at a clock edge, the block SHALL set: FSM=IDLE, synchronizer flops=1, debounce counter=0, prescaler=0, accumulator=0.
REQ-038 While iRst is high at a clock edge, outputs SHALL be: oProchotDeb=0, oCpuOrigin=0, oIrq_n=1, oEventCnt=0, oLastDurMs=0.
REQ-039 Reset SHALL take priority over all other inputs, including mid-assertion and a simultaneous iAck.

Verification
REQ-040 Scenario: PWROK=1, SKTOCC_N=0, drive_n=1, pin low for 3 ms -> oProchotDeb rises 6 cycles after the pin falls; oEventCnt=1; oIrq_n=0; oCpuOrigin=1; after release plus 6 cycles, oLastDurMs=3.
REQ-041 Scenario: pin low pulses of 3 cycles, repeated -> oProchotDeb stays 0, oEventCnt stays 0, oIrq_n stays 1.
REQ-042 Scenario: drive_n=0 while pin low for 2 ms -> oCpuOrigin=0, oEventCnt unchanged, oIrq_n=1, oLastDurMs=2.
REQ-043 Scenario: iAck on the same cycle as a CPU-origin entry -> oIrq_n=0; iAck one cycle later -> oIrq_n=1.
REQ-044 Scenario: 300 CPU-origin assertions -> oEventCnt=255; a 70 s assertion -> oLastDurMs=65535.
REQ-045 Scenario: PWROK drops mid-assertion -> oProchotDeb=0 next cycle and oLastDurMs unchanged; iRst mid-assertion -> all outputs return to their reset values.
